// File: rtl/astro_mem_pkg.sv
// astro_mem_pkg: shared loader state enum, ROM index codes and default sizes
package astro_mem_pkg;
    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, HOLD} ld_state_e;
    localparam logic [7:0] IDX_BIOS = 8'd0;
    localparam logic [7:0] IDX_CART = 8'd1;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_HOLD_CYCLES = 16;
endpackage

// File: rtl/rom_load_ctrl_if.sv
// rom_load_ctrl_if: HPS ioctl download bus between the host (master) and the loader (slave)
interface rom_load_ctrl_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, input ioctl_wait);
    modport slave (input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, output ioctl_wait);
endinterface

// File: rtl/cart_mirror_mask.sv
// cart_mirror_mask: mask = P-1 for the smallest power of two P >= size; size 0 gives all ones
module cart_mirror_mask
    import astro_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W:0]   size,
    output logic [ADDR_W-1:0] mask
);
    logic [ADDR_W:0] m;
    assign m = size - (ADDR_W+1)'(1);
    for (genvar i = 0; i < ADDR_W; i++) begin : g_smear
        assign mask[i] = |m[ADDR_W:i];
    end
endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: splits HPS 16-bit download words into BIOS/cart RAM byte writes; CART_MIRROR_EN masks CPU cart address
module rom_load_ctrl
    import astro_mem_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk_sys,
    input  logic              reset_l,
    rom_load_ctrl_if.slave    io,
    input  logic [ADDR_W-1:0] cpu_cart_addr,
    input  logic [ADDR_W-1:0] cpu_bios_addr,
    output logic [ADDR_W-1:0] mem_cart_addr,
    output logic [ADDR_W-1:0] mem_bios_addr,
    output logic [7:0]        mem_din,
    output logic              mem_cart_we,
    output logic              mem_bios_we,
    output logic [ADDR_W:0]   cart_size,
    output logic              load_err,
    output logic              sys_reset_l
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    ld_state_e       state_q, state_d;
    logic            dl_q, dl_d;
    logic [24:0]     addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic [7:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0] size_q, size_d;
    logic            err_q, err_d;
    logic            wr_st, in_range, idx_ok, rise, fall, loader;
    logic [ADDR_W:0]   new_end;
    logic [ADDR_W-1:0] ld_addr, cpu_cart_eff;
    assign wr_st    = state_q == WR_LO || state_q == WR_HI;
    assign in_range = addr_q[24:ADDR_W] == '0;
    assign idx_ok   = idx_q == IDX_BIOS || idx_q == IDX_CART;
    assign rise     = io.ioctl_download && !dl_q;
    assign fall     = !io.ioctl_download && dl_q;
    assign new_end  = {1'b0, addr_q[ADDR_W-1:0]} + (ADDR_W+1)'(2);
    assign ld_addr  = addr_q[ADDR_W-1:0] + ADDR_W'(state_q == WR_HI);
    always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            dl_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= dl_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        dl_d    = io.ioctl_download;
        addr_d  = addr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (io.ioctl_wr) begin
                    state_d = WR_LO;
                    addr_d  = io.ioctl_addr;
                    data_d  = io.ioctl_dout;
                    idx_d   = io.ioctl_index;
                end else if (fall) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            WR_LO: state_d = WR_HI;
            // a download that ended during WR_LO is seen here, after both bytes
            WR_HI: begin
                state_d = io.ioctl_download ? IDLE : HOLD;
                cnt_d   = '0;
            end
            default: begin
                state_d = cnt_q == CW'(HOLD_CYCLES - 1) ? IDLE : HOLD;
                cnt_d   = cnt_q + CW'(1);
            end
        endcase
    end
    always_comb begin
        err_d  = err_q;
        size_d = (rise && io.ioctl_index == IDX_CART) ? '0 : size_q;
        if (rise && (io.ioctl_index == IDX_BIOS || io.ioctl_index == IDX_CART))
            err_d = 1'b0;
        if (state_q == WR_LO && !(in_range && idx_ok))
            err_d = 1'b1;
        if (state_q == WR_LO && in_range && idx_q == IDX_CART && new_end > size_d)
            size_d = new_end;
    end
`ifdef CART_MIRROR_EN
    logic [ADDR_W-1:0] mirror_mask;
    cart_mirror_mask #(.ADDR_W(ADDR_W)) u_mask (.size(size_q), .mask(mirror_mask));
    assign cpu_cart_eff = cpu_cart_addr & mirror_mask;
`else
    assign cpu_cart_eff = cpu_cart_addr;
`endif
    assign loader        = io.ioctl_download || state_q != IDLE;
    assign io.ioctl_wait = wr_st;
    assign mem_cart_we   = wr_st && in_range && idx_q == IDX_CART;
    assign mem_bios_we   = wr_st && in_range && idx_q == IDX_BIOS;
    assign mem_din       = state_q == WR_LO ? data_q[7:0] : state_q == WR_HI ? data_q[15:8] : 8'h00;
    assign mem_cart_addr = loader ? ld_addr : cpu_cart_eff;
    assign mem_bios_addr = loader ? ld_addr : cpu_bios_addr;
    assign cart_size     = size_q;
    assign load_err      = err_q;
    assign sys_reset_l   = reset_l && !io.ioctl_download && state_q == IDLE;
endmodule
